// File: rtl/umem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | umem_pkg                                                                   |
// | Shared UMEM_OK status codes, access-size codes and memop stage states.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package umem_pkg;

   localparam logic [1:0] UMEM_OK_READY = 2'b00;
   localparam logic [1:0] UMEM_OK_OK    = 2'b01;
   localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
   localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

   localparam logic [1:0] MEMSZ_B = 2'b00;
   localparam logic [1:0] MEMSZ_W = 2'b01;
   localparam logic [1:0] MEMSZ_L = 2'b10;
   localparam logic [1:0] MEMSZ_Q = 2'b11;

   localparam logic [6:0] REGID_NONE = 7'h7F;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_FLT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/memop64_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memop64_lane                                                               |
// | Byte-lane steering: byte enables, store shift, load extract/extend and     |
// | alignment check. Purely combinational.                                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module memop64_lane
   import umem_pkg::*;
(
   input  logic [2:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic [63:0] st_data_i,
   input  logic [2:0]  ld_lane_i,
   input  logic [1:0]  ld_size_i,
   input  logic        ld_zext_i,
   input  logic [63:0] ld_data_i,
   output logic [7:0]  byte_en_o,
   output logic [63:0] st_data_o,
   output logic [63:0] ld_data_o,
   output logic        misalign_o
);

   logic [63:0] w_ld_shift;

   always_comb begin
      byte_en_o  = 8'h00;
      misalign_o = 1'b0;
      case (size_i)
         MEMSZ_B: byte_en_o = 8'h01 << addr_lo_i;
         MEMSZ_W: begin
            byte_en_o  = 8'h03 << addr_lo_i;
            misalign_o = addr_lo_i[0];
         end
         MEMSZ_L: begin
            byte_en_o  = 8'h0F << addr_lo_i;
            misalign_o = |addr_lo_i[1:0];
         end
         default: begin
            byte_en_o  = 8'hFF;
            misalign_o = |addr_lo_i;
         end
      endcase
   end

   assign st_data_o  = st_data_i << {addr_lo_i, 3'b000};
   assign w_ld_shift = ld_data_i >> {ld_lane_i, 3'b000};

   // zext=1 fills with zeros, zext=0 replicates the top bit of the field
   always_comb begin
      ld_data_o = w_ld_shift;
      case (ld_size_i)
         MEMSZ_B: ld_data_o = {{56{~ld_zext_i & w_ld_shift[7]}},  w_ld_shift[7:0]};
         MEMSZ_W: ld_data_o = {{48{~ld_zext_i & w_ld_shift[15]}}, w_ld_shift[15:0]};
         MEMSZ_L: ld_data_o = {{32{~ld_zext_i & w_ld_shift[31]}}, w_ld_shift[31:0]};
         default: ld_data_o = w_ld_shift;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/memop64_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memop64_stage                                                              |
// | Memory-access stage: one aligned 64-bit bus transaction per request,       |
// | UMEM_OK handshake back to execute, load result for writeback.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module memop64_stage
   import umem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] exMemAddr,
   input  logic [63:0] exMemData,
   input  logic        exMemLoad,
   input  logic        exMemStore,
   input  logic [4:0]  exMemOpMode,
   input  logic [7:0]  exMemOpCmd2,
   input  logic [6:0]  exRegIdRn,
   output logic [1:0]  memOutOK,
   output logic [6:0]  regIdRw,
   output logic [63:0] regValRw,
   output logic [7:0]  memOutCmd2,
   output logic [63:0] busAddr,
   output logic [63:0] busDataOut,
   output logic [7:0]  busByteEn,
   output logic        busOE,
   output logic        busWE,
   input  logic [63:0] busDataIn,
   input  logic [1:0]  busOK
);

   localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [63:0] addr_q, wdata_q, rval_q;
   logic [7:0]  be_q, cmd2_q;
   logic        oe_q, we_q, zext_q, isld_q;
   logic [1:0]  size_q;
   logic [2:0]  lane_q;
   logic [6:0]  rn_q;
   logic [15:0] cnt_q;

   logic        w_req, w_bad, w_misalign, w_timeout;
   logic [7:0]  w_be;
   logic [63:0] w_wdata, w_ldval;
   logic [15:0] w_cnt_inc;
   logic        w_unused_mode;

   assign w_req         = exMemLoad | exMemStore;
   assign w_bad         = (exMemLoad & exMemStore) | w_misalign;
   assign w_cnt_inc     = cnt_q + 16'd1;
   assign w_timeout     = (w_cnt_inc == c_TIMEOUT);
   assign w_unused_mode = ^exMemOpMode[4:3];

   memop64_lane u_lane (
      .addr_lo_i  (exMemAddr[2:0]),
      .size_i     (exMemOpMode[1:0]),
      .st_data_i  (exMemData),
      .ld_lane_i  (lane_q),
      .ld_size_i  (size_q),
      .ld_zext_i  (zext_q),
      .ld_data_i  (busDataIn),
      .byte_en_o  (w_be),
      .st_data_o  (w_wdata),
      .ld_data_o  (w_ldval),
      .misalign_o (w_misalign)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // READY (and any other non-OK/non-FAULT code) in REQ is treated as HOLD
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_req) state_d = w_bad ? ST_FLT : ST_REQ;
         ST_REQ: begin
            if (busOK == UMEM_OK_OK)         state_d = ST_DONE;
            else if (busOK == UMEM_OK_FAULT) state_d = ST_FLT;
            else if (w_timeout)              state_d = ST_FLT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: if (!w_req) state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      memOutOK = UMEM_OK_READY;
      regIdRw  = REGID_NONE;
      case (state_q)
         ST_IDLE: if (w_req) memOutOK = UMEM_OK_HOLD;
         ST_REQ:  memOutOK = UMEM_OK_HOLD;
         ST_DONE: begin
            memOutOK = UMEM_OK_OK;
            if (isld_q) regIdRw = rn_q;
         end
         default: memOutOK = UMEM_OK_FAULT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rval_q  <= '0;
         be_q    <= '0;
         cmd2_q  <= '0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         zext_q  <= 1'b0;
         isld_q  <= 1'b0;
         size_q  <= MEMSZ_B;
         lane_q  <= '0;
         rn_q    <= REGID_NONE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (w_req) begin
               addr_q  <= {exMemAddr[63:3], 3'b000};
               wdata_q <= w_wdata;
               be_q    <= w_be;
               oe_q    <= exMemLoad & ~w_bad;
               we_q    <= exMemStore & ~w_bad;
               size_q  <= exMemOpMode[1:0];
               zext_q  <= exMemOpMode[2];
               lane_q  <= exMemAddr[2:0];
               rn_q    <= exRegIdRn;
               cmd2_q  <= exMemOpCmd2;
               isld_q  <= exMemLoad;
               cnt_q   <= '0;
            end
            ST_REQ: begin
               if (busOK == UMEM_OK_OK) begin
                  if (isld_q) rval_q <= w_ldval;
                  oe_q <= 1'b0;
                  we_q <= 1'b0;
               end else if (busOK == UMEM_OK_FAULT) begin
                  oe_q <= 1'b0;
                  we_q <= 1'b0;
               end else begin
                  cnt_q <= w_cnt_inc;
                  if (w_timeout) begin
                     oe_q <= 1'b0;
                     we_q <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign regValRw   = rval_q;
   assign memOutCmd2 = cmd2_q;
   assign busAddr    = addr_q;
   assign busDataOut = wdata_q;
   assign busByteEn  = be_q;
   assign busOE      = oe_q;
   assign busWE      = we_q;

endmodule
`default_nettype wire

// File: tb/tb_memop64_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memop64_stage                                                           |
// | Directed vector table plus random transactions against a reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_memop64_stage;
   import umem_pkg::*;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic        ld;
      logic        st;
      logic [4:0]  mode;
      logic [6:0]  rn;
      logic [7:0]  cmd2;
      int          nhold;
      logic [1:0]  fin;
      logic [63:0] rdata;
      logic        efault_dec;
      logic [7:0]  ebe;
      logic [63:0] ewdata;
      logic [63:0] erval;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] exMemAddr, exMemData, busDataIn;
   logic        exMemLoad, exMemStore;
   logic [4:0]  exMemOpMode;
   logic [7:0]  exMemOpCmd2;
   logic [6:0]  exRegIdRn;
   logic [1:0]  busOK;
   logic [1:0]  memOutOK;
   logic [6:0]  regIdRw;
   logic [63:0] regValRw, busAddr, busDataOut;
   logic [7:0]  memOutCmd2, busByteEn;
   logic        busOE, busWE;

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   memop64_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset),
      .exMemAddr(exMemAddr), .exMemData(exMemData),
      .exMemLoad(exMemLoad), .exMemStore(exMemStore),
      .exMemOpMode(exMemOpMode), .exMemOpCmd2(exMemOpCmd2), .exRegIdRn(exRegIdRn),
      .memOutOK(memOutOK), .regIdRw(regIdRw), .regValRw(regValRw),
      .memOutCmd2(memOutCmd2), .busAddr(busAddr), .busDataOut(busDataOut),
      .busByteEn(busByteEn), .busOE(busOE), .busWE(busWE),
      .busDataIn(busDataIn), .busOK(busOK)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: expectations from size in bytes and byte offset.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int          nb;
      int          a;
      logic [63:0] mask;
      logic [63:0] val;
      r    = v;
      nb   = 1 << v.mode[1:0];
      a    = int'(v.addr[2:0]);
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
      r.efault_dec = (v.ld && v.st) || ((a % nb) != 0);
      r.ebe        = 8'(((1 << nb) - 1) << a);
      r.ewdata     = v.data << (8 * a);
      val = (v.rdata >> (8 * a)) & mask;
      if (!v.mode[2] && nb < 8 && val[8 * nb - 1]) val = val | ~mask;
      r.erval = val;
      return r;
   endfunction

   // Called right after a negedge; leaves the DUT idle at a negedge.
   task automatic run_vec(input vec_t v, input string tag);
      exMemAddr   = v.addr;
      exMemData   = v.data;
      exMemLoad   = v.ld;
      exMemStore  = v.st;
      exMemOpMode = v.mode;
      exMemOpCmd2 = v.cmd2;
      exRegIdRn   = v.rn;
      busOK       = UMEM_OK_HOLD;
      busDataIn   = '0;
      #1 chk($sformatf("%s.ok_idle", tag), 64'(memOutOK), 64'(UMEM_OK_HOLD));
      @(negedge clock);
      if (v.efault_dec) begin
         chk($sformatf("%s.ok_flt", tag), 64'(memOutOK), 64'(UMEM_OK_FAULT));
         chk($sformatf("%s.oe_flt", tag), 64'(busOE), 64'd0);
         chk($sformatf("%s.we_flt", tag), 64'(busWE), 64'd0);
         @(negedge clock);
         chk($sformatf("%s.ok_flt2", tag), 64'(memOutOK), 64'(UMEM_OK_FAULT));
         chk($sformatf("%s.oe_flt2", tag), 64'(busOE), 64'd0);
         exMemLoad  = 1'b0;
         exMemStore = 1'b0;
         @(negedge clock);
         chk($sformatf("%s.ok_rdy", tag), 64'(memOutOK), 64'(UMEM_OK_READY));
         return;
      end
      chk($sformatf("%s.addr", tag), busAddr, {v.addr[63:3], 3'b000});
      chk($sformatf("%s.be", tag), 64'(busByteEn), 64'(v.ebe));
      chk($sformatf("%s.wdata", tag), busDataOut, v.ewdata);
      chk($sformatf("%s.oe", tag), 64'(busOE), 64'(v.ld));
      chk($sformatf("%s.we", tag), 64'(busWE), 64'(v.st));
      chk($sformatf("%s.cmd2", tag), 64'(memOutCmd2), 64'(v.cmd2));
      chk($sformatf("%s.rw_req", tag), 64'(regIdRw), 64'(REGID_NONE));
      for (int i = 0; i < v.nhold; i++) begin
         busOK = UMEM_OK_HOLD;
         #1 chk($sformatf("%s.ok_hold%0d", tag, i), 64'(memOutOK), 64'(UMEM_OK_HOLD));
         @(negedge clock);
      end
      busOK     = v.fin;
      busDataIn = v.rdata;
      #1 chk($sformatf("%s.ok_last", tag), 64'(memOutOK), 64'(UMEM_OK_HOLD));
      @(negedge clock);
      busOK     = UMEM_OK_HOLD;
      busDataIn = {$urandom(), $urandom()};
      if (v.fin == UMEM_OK_OK) begin
         chk($sformatf("%s.ok_done", tag), 64'(memOutOK), 64'(UMEM_OK_OK));
         chk($sformatf("%s.rw_done", tag), 64'(regIdRw), 64'(v.ld ? v.rn : REGID_NONE));
         if (v.ld) chk($sformatf("%s.rval", tag), regValRw, v.erval);
      end else begin
         chk($sformatf("%s.ok_lflt", tag), 64'(memOutOK), 64'(UMEM_OK_FAULT));
         chk($sformatf("%s.rw_lflt", tag), 64'(regIdRw), 64'(REGID_NONE));
      end
      chk($sformatf("%s.oe_end", tag), 64'(busOE), 64'd0);
      chk($sformatf("%s.we_end", tag), 64'(busWE), 64'd0);
      exMemLoad  = 1'b0;
      exMemStore = 1'b0;
      @(negedge clock);
      chk($sformatf("%s.ok_rdy", tag), 64'(memOutOK), 64'(UMEM_OK_READY));
      chk($sformatf("%s.rw_idle", tag), 64'(regIdRw), 64'(REGID_NONE));
   endtask

   vec_t tbl [14];
   vec_t rv;

   initial begin
      tbl[0]  = '{64'h1004, 64'h0, 1'b1, 1'b0, 5'b00010, 7'd5, 8'h3C, 2, UMEM_OK_OK,
                  64'h8000_0000_0000_0000, 1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000};
      tbl[1]  = '{64'h1004, 64'h0, 1'b1, 1'b0, 5'b00110, 7'd5, 8'h3D, 2, UMEM_OK_OK,
                  64'h8000_0000_0000_0000, 1'b0, 8'hF0, 64'h0, 64'h0000_0000_8000_0000};
      tbl[2]  = '{64'h2003, 64'hAB, 1'b0, 1'b1, 5'b00000, 7'd9, 8'h11, 0, UMEM_OK_OK,
                  64'h0, 1'b0, 8'h08, 64'hAB00_0000, 64'h0};
      tbl[3]  = '{64'h3004, 64'h0, 1'b1, 1'b0, 5'b00011, 7'd3, 8'h22, 0, UMEM_OK_OK,
                  64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
      tbl[4]  = '{64'h10, 64'h1234, 1'b1, 1'b0, 5'b00001, 7'd7, 8'h33, 3, UMEM_OK_HOLD,
                  64'h0, 1'b0, 8'h03, 64'h1234, 64'h0};
      tbl[5]  = '{64'h4000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 5'b00011, 7'd1, 8'h44, 1,
                  UMEM_OK_FAULT, 64'h0, 1'b0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
      tbl[6]  = '{64'h5000, 64'h0, 1'b1, 1'b1, 5'b00011, 7'd2, 8'h55, 0, UMEM_OK_OK,
                  64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
      tbl[7]  = '{64'h5001, 64'h0, 1'b1, 1'b0, 5'b00001, 7'd2, 8'h56, 0, UMEM_OK_OK,
                  64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
      tbl[8]  = '{64'h6002, 64'h0, 1'b0, 1'b1, 5'b00010, 7'd2, 8'h57, 0, UMEM_OK_OK,
                  64'h0, 1'b1, 8'h00, 64'h0, 64'h0};
      tbl[9]  = '{64'h6004, 64'h5566_7788, 1'b0, 1'b1, 5'b00010, 7'd4, 8'h66, 3,
                  UMEM_OK_READY, 64'h0, 1'b0, 8'hF0, 64'h5566_7788_0000_0000, 64'h0};
      tbl[10] = '{64'h7008, 64'h0, 1'b1, 1'b0, 5'b00111, 7'd10, 8'h77, 1, UMEM_OK_OK,
                  64'h8123_4567_89AB_CDEF, 1'b0, 8'hFF, 64'h0, 64'h8123_4567_89AB_CDEF};
      tbl[11] = '{64'h7, 64'h5A, 1'b1, 1'b0, 5'b00000, 7'd11, 8'h88, 0, UMEM_OK_OK,
                  64'hFE00_0000_0000_0000, 1'b0, 8'h80, 64'h5A00_0000_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFE};
      tbl[12] = '{64'h7, 64'h5A, 1'b1, 1'b0, 5'b00100, 7'd12, 8'h99, 0, UMEM_OK_OK,
                  64'hFE00_0000_0000_0000, 1'b0, 8'h80, 64'h5A00_0000_0000_0000, 64'hFE};
      tbl[13] = '{64'h8006, 64'h0, 1'b1, 1'b0, 5'b11001, 7'd13, 8'hAA, 2, UMEM_OK_OK,
                  64'h8001_0000_0000_0000, 1'b0, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001};

      reset = 1'b1;
      exMemAddr = '0; exMemData = '0; exMemLoad = 1'b0; exMemStore = 1'b0;
      exMemOpMode = '0; exMemOpCmd2 = '0; exRegIdRn = '0;
      busOK = UMEM_OK_READY; busDataIn = '0;
      repeat (3) @(negedge clock);
      chk("rst.ok", 64'(memOutOK), 64'(UMEM_OK_READY));
      chk("rst.rw", 64'(regIdRw), 64'(REGID_NONE));
      chk("rst.rval", regValRw, 64'h0);
      chk("rst.cmd2", 64'(memOutCmd2), 64'h0);
      chk("rst.addr", busAddr, 64'h0);
      chk("rst.wdata", busDataOut, 64'h0);
      chk("rst.be", 64'(busByteEn), 64'h0);
      chk("rst.oe", 64'(busOE), 64'h0);
      chk("rst.we", 64'(busWE), 64'h0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Reset abandons an in-flight load; a late bus OK must be ignored.
      exMemAddr = 64'h9000; exMemLoad = 1'b1; exMemOpMode = 5'b00010;
      exRegIdRn = 7'd20; busOK = UMEM_OK_HOLD;
      @(negedge clock);
      chk("rstreq.oe", 64'(busOE), 64'd1);
      reset = 1'b1;
      exMemLoad = 1'b0;
      @(negedge clock);
      chk("rstreq.oe_off", 64'(busOE), 64'd0);
      chk("rstreq.ok", 64'(memOutOK), 64'(UMEM_OK_READY));
      reset = 1'b0;
      busOK = UMEM_OK_OK;
      busDataIn = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clock);
      chk("rstreq.late_ok", 64'(memOutOK), 64'(UMEM_OK_READY));
      chk("rstreq.late_rw", 64'(regIdRw), 64'(REGID_NONE));
      busOK = UMEM_OK_HOLD;
      @(negedge clock);
      chk("rstreq.idle_ok", 64'(memOutOK), 64'(UMEM_OK_READY));
      chk("rstreq.rval", regValRw, 64'h0);

      for (int n = 0; n < 60; n++) begin
         int sel;
         int nb;
         rv.addr  = {$urandom(), $urandom()};
         rv.data  = {$urandom(), $urandom()};
         rv.rdata = {$urandom(), $urandom()};
         rv.mode  = 5'($urandom());
         rv.rn    = 7'($urandom_range(0, 126));
         rv.cmd2  = 8'($urandom());
         nb = 1 << rv.mode[1:0];
         if ($urandom_range(0, 3) != 0) rv.addr[2:0] = rv.addr[2:0] & ~3'(nb - 1);
         sel = $urandom_range(0, 9);
         rv.ld = (sel <= 5);
         rv.st = (sel == 0) || (sel > 5);
         rv.nhold = $urandom_range(0, 3);
         sel = $urandom_range(0, 15);
         if (sel == 0) begin
            rv.fin = UMEM_OK_HOLD;
            rv.nhold = 3;
         end else if (sel == 1) begin
            rv.fin = UMEM_OK_READY;
            rv.nhold = 3;
         end else if (sel <= 3) begin
            rv.fin = UMEM_OK_FAULT;
         end else begin
            rv.fin = UMEM_OK_OK;
         end
         rv = model(rv);
         run_vec(rv, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memop64_stage.md
Name: memop64_stage

Overview:
Memory-access stage directly downstream of the 64-bit combined execute stage. It consumes that stage's memAddr/memData/memLoad/memStore/memOpMode/memOpCmd2 request and runs one aligned 64-bit bus transaction per request. It performs byte-lane steering and load sign/zero extension. It returns a UMEM_OK status that stalls execute (HOLD) until the access completes or faults, and supplies the load result for register writeback.

Parameters:
TIMEOUT_CYCLES, 255, bus HOLD cycles tolerated in REQ before the stage declares FAULT (1..65535)

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high reset
exMemAddr  in  64  effective address from execute
exMemData  in  64  store data (right-justified)
exMemLoad  in  1  load request
exMemStore  in  1  store request
exMemOpMode  in  5  [1:0] size 00=B 01=W 10=L 11=Q; [2] 1=zero-extend load; [4:3] reserved, ignored
exMemOpCmd2  in  8  EX chain command, carried to output
exRegIdRn  in  7  load destination register id
memOutOK  out  2  UMEM_OK status to execute
regIdRw  out  7  writeback register id (7'h7F = no write)
regValRw  out  64  load result
memOutCmd2  out  8  captured exMemOpCmd2
busAddr  out  64  aligned address ({addr[63:3],3'b000})
busDataOut  out  64  lane-shifted store data
busByteEn  out  8  byte enables
busOE  out  1  bus read strobe
busWE  out  1  bus write strobe
busDataIn  in  64  bus read data
busOK  in  2  bus status (UMEM_OK encoding)

Behaviour:
- UMEM_OK encoding: READY=2'b00, OK=2'b01, HOLD=2'b10, FAULT=2'b11.
- States: IDLE, REQ, DONE, FLT. Request = exMemLoad|exMemStore.
- Reset: state=IDLE; memOutOK=READY; regIdRw=7'h7F; regValRw=0; memOutCmd2=0; busAddr=0; busDataOut=0; busByteEn=0; busOE=0; busWE=0; timeout counter=0.
- memOutOK is combinational from state and request:
  - HOLD in IDLE with request present, and throughout REQ.
  - OK in DONE.
  - FAULT in FLT.
  - READY in IDLE with no request.
- IDLE with request: decode and register the request, then go to REQ next edge. Registered fields: busAddr, busByteEn, busDataOut=exMemData<<(8*addr[2:0]), busOE=load, busWE=store, size, extend, lane, Rn, Cmd2.
- IDLE goes to FLT instead (no bus strobes) on any of:
  - load and store both set;
  - misaligned address: W with addr[0]!=0, L with addr[1:0]!=0, Q with addr[2:0]!=0.
- Byte enables: B=1<<a, W=3<<a, L=15<<a, Q=8'hFF, where a=addr[2:0].
- REQ, per bus status:
  - busOK=HOLD: stay in REQ and increment the counter. When the counter reaches TIMEOUT_CYCLES, go to FLT.
  - busOK=OK: capture the load result, drop busOE/busWE, go to DONE.
  - busOK=FAULT: drop strobes, go to FLT.
  - busOK=READY: treated as HOLD.
- Load result: busDataIn>>(8*lane), truncated to size, then sign-extended (extend=0) or zero-extended (extend=1) to 64. Q ignores extend.
- Writeback: regIdRw=captured Rn for loads and 7'h7F for stores; valid only in DONE. Outside DONE, regIdRw=7'h7F.
- DONE lasts exactly one cycle, then IDLE. Execute advances on that edge, so a request present in the following IDLE cycle is a new request. Minimum latency is 3 cycles (IDLE sample, REQ with busOK=OK, DONE).
- FLT holds until request deasserts (checked each cycle), then IDLE. Strobes stay low in FLT.
- Counter clears on entry to REQ.
- Reset mid-operation: abandon the transaction immediately; strobes low next edge. Any bus completion arriving afterwards is ignored.

Decomposition:
- Shared package (umem_pkg):
  - UMEM_OK_READY, UMEM_OK_OK, UMEM_OK_HOLD, UMEM_OK_FAULT;
  - size codes MEMSZ_B, MEMSZ_W, MEMSZ_L, MEMSZ_Q;
  - the no-write register id constant REGID_NONE=7'h7F;
  - state encoding.
- One sub-module, memop64_lane (pure combinational), containing:
  - byte-enable generation;
  - store shift;
  - load extract and extend;
  - misalignment check.
- The FSM and timeout counter stay in memop64_stage.

Test Plan:
- Load L, addr=0x1004, mode=00010, bus returns OK after 2 HOLD cycles, busDataIn=0x80000000_00000000: byteEn=0xF0, busAddr=0x1000; memOutOK HOLD for 4 cycles then OK for 1; regValRw=0xFFFFFFFF_80000000; regIdRw=Rn.
- Same load with mode=00110 (zero-extend): regValRw=0x00000000_80000000.
- Store B, addr=0x2003, data=0xAB: busDataOut=0xAB000000, byteEn=0x08, busWE=1 for one REQ cycle; DONE gives regIdRw=7'h7F.
- Misaligned Q load at addr=0x3004: no busOE ever asserted; memOutOK=FAULT until exMemLoad drops, then READY.
- TIMEOUT_CYCLES=4, bus held at HOLD: FLT entered on the 4th HOLD cycle, strobes low; busOK=FAULT mid-REQ gives the same result.
- Reset asserted during REQ with busOE=1: next edge busOE=0, state IDLE, memOutOK=READY; a busOK=OK pulse one cycle later produces no DONE.
